// File: rtl/tpu_operand_sequencer_pkg.sv
// Shared types and constants for the operand sequencer.
//   bank_state_t : life cycle of one ping-pong operand bank
//   rd_state_t   : read/issue FSM states
//   flush_len()  : zero-injection cycles needed to drain the skew wavefront
package tpu_operand_sequencer_pkg;

    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_DATA_SIZE   = 16;
    localparam int DEF_MAX_DEPTH   = 16;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        READING
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        WAIT
    } rd_state_t;

    // Longest skew path is 2N-1 cycles (lane N-1 of both operands meeting
    // at the far corner PE), so that many zero slices complete a tile.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/tpu_operand_sequencer_if.sv
// Load stream, array feed and drain handshake of the operand sequencer.
//   master : host/DMA + array side (drives load_*, drain_ack)
//   slave  : the sequencer (drives load_ready, feeds, pe_*, tile_done, overflow)
// Lane j of a vector sits at [j*DW +: DW].
interface tpu_operand_sequencer_if #(
    parameter int N  = 8,
    parameter int DW = 16
);
    logic            load_valid;
    logic            load_ready;
    logic [N*DW-1:0] load_top;
    logic [N*DW-1:0] load_left;
    logic            load_last;
    logic            load_accum;
    logic [N*DW-1:0] top_feed;
    logic [N*DW-1:0] left_feed;
    logic            pe_enable;
    logic            pe_clear;
    logic            tile_done;
    logic            drain_ack;
    logic            overflow;

    modport master (
        output load_valid, load_top, load_left, load_last, load_accum, drain_ack,
        input  load_ready, top_feed, left_feed, pe_enable, pe_clear, tile_done, overflow
    );

    modport slave (
        input  load_valid, load_top, load_left, load_last, load_accum, drain_ack,
        output load_ready, top_feed, left_feed, pe_enable, pe_clear, tile_done, overflow
    );

endinterface

// File: rtl/tpu_operand_sequencer_skew_line.sv
// Per-lane delay line: q_o follows d_i after DEPTH clocks.
//   clk_i, rst_n_i : clock, async active-low reset (clears every stage)
//   d_i            : lane input
//   q_o            : lane output, DEPTH cycles late
module tpu_operand_sequencer_skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/tpu_operand_sequencer.sv
// Operand front end for the systolic array: two ping-pong operand banks
// filled from a valid/ready slice stream, a read FSM that streams one bank
// per tile through per-lane skew lines, then flushes and holds tile_done
// until the results are drained.
//   clk_i   : rising-edge clock
//   rst_n_i : asynchronous active-low reset
//   bus     : load stream, skewed feeds, pe_enable/pe_clear, tile_done/drain_ack, overflow
//
// Read FSM
//   state  | meaning
//   IDLE   | waiting for bank[rd_sel] FULL; claim cycle pulses pe_clear unless accumulating
//   STREAM | one slice per cycle for depth[rd_sel] cycles, pe_enable high
//   FLUSH  | 2N-1 zero cycles to finish the skew wavefront, pe_enable high
//   WAIT   | tile_done high until drain_ack
module tpu_operand_sequencer
    import tpu_operand_sequencer_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int MAX_DEPTH   = DEF_MAX_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    tpu_operand_sequencer_if.slave bus
);

    localparam int N     = MATRIX_SIZE;
    localparam int DW    = DATA_SIZE;
    localparam int VW    = N * DW;
    localparam int PTR_W = $clog2(MAX_DEPTH);
    localparam int DEP_W = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_DEPTH + 2 * N) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(flush_len(N) - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_DEPTH - 1);

    bank_state_t      bank_q  [2];
    bank_state_t      bank_d  [2];
    logic [DEP_W-1:0] depth_q [2];
    logic [DEP_W-1:0] depth_d [2];
    logic             accum_q [2];
    logic             accum_d [2];
    logic             wr_sel_q, wr_sel_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             overflow_q, overflow_d;
    logic             rdy_en_q;

    rd_state_t        rd_state_q, rd_state_d;
    logic             rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_claim, rd_release;

    logic             load_ready, accept, last_eff;
    logic             pe_enable, pe_clear, tile_done;

    logic [VW-1:0]    top_mem  [2][MAX_DEPTH];
    logic [VW-1:0]    left_mem [2][MAX_DEPTH];
    logic [VW-1:0]    top_slice, left_slice;
    logic [VW-1:0]    top_feed, left_feed;

    // rdy_en_q keeps load_ready low during reset and for the first edge after it.
    assign load_ready = rdy_en_q &&
                        (bank_q[wr_sel_q] == EMPTY || bank_q[wr_sel_q] == FILLING);
    assign accept     = bus.load_valid && load_ready;
    // A slice landing in the final row is the end of the tile, flagged or not.
    assign last_eff   = bus.load_last || (wr_ptr_q == PTR_LAST);

    // Load side and read side never touch the same bank state in one cycle:
    // loads only move EMPTY/FILLING banks, the read FSM only FULL/READING ones.
    always_comb begin
        bank_d     = bank_q;
        depth_d    = depth_q;
        accum_d    = accum_q;
        wr_sel_d   = wr_sel_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (accept) begin
            if (bank_q[wr_sel_q] == EMPTY) begin
                accum_d[wr_sel_q] = bus.load_accum;
                bank_d[wr_sel_q]  = FILLING;
            end
            if (last_eff) begin
                bank_d[wr_sel_q]  = FULL;
                depth_d[wr_sel_q] = {1'b0, wr_ptr_q} + DEP_W'(1);
                wr_sel_d          = !wr_sel_q;
                wr_ptr_d          = '0;
                if (!bus.load_last) overflow_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
        if (rd_claim)   bank_d[rd_sel_q] = READING;
        if (rd_release) bank_d[rd_sel_q] = EMPTY;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_cnt_d   = rd_cnt_q;
        rd_claim   = 1'b0;
        rd_release = 1'b0;
        pe_enable  = 1'b0;
        pe_clear   = 1'b0;
        tile_done  = 1'b0;
        unique case (rd_state_q)
            IDLE: begin
                if (bank_q[rd_sel_q] == FULL) begin
                    rd_claim   = 1'b1;
                    pe_clear   = !accum_q[rd_sel_q];
                    rd_state_d = STREAM;
                    rd_cnt_d   = '0;
                end
            end
            STREAM: begin
                pe_enable = 1'b1;
                if (rd_cnt_q + CNT_ONE == CNT_W'(depth_q[rd_sel_q])) begin
                    rd_release = 1'b1;
                    rd_sel_d   = !rd_sel_q;
                    rd_state_d = FLUSH;
                    rd_cnt_d   = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                end
            end
            FLUSH: begin
                pe_enable = 1'b1;
                if (rd_cnt_q == FLUSH_LAST) begin
                    rd_state_d = WAIT;
                    rd_cnt_d   = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                end
            end
            WAIT: begin
                tile_done = 1'b1;
                if (bus.drain_ack) rd_state_d = IDLE;
            end
            default: rd_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_q[0]  <= EMPTY;
            bank_q[1]  <= EMPTY;
            depth_q[0] <= '0;
            depth_q[1] <= '0;
            accum_q[0] <= 1'b0;
            accum_q[1] <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rdy_en_q   <= 1'b0;
            rd_state_q <= IDLE;
            rd_sel_q   <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            bank_q     <= bank_d;
            depth_q    <= depth_d;
            accum_q    <= accum_d;
            wr_sel_q   <= wr_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            rdy_en_q   <= 1'b1;
            rd_state_q <= rd_state_d;
            rd_sel_q   <= rd_sel_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Bank storage; contents are only read while the bank is claimed, so no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            top_mem[wr_sel_q][wr_ptr_q]  <= bus.load_top;
            left_mem[wr_sel_q][wr_ptr_q] <= bus.load_left;
        end
    end

    assign top_slice  = (rd_state_q == STREAM) ? top_mem[rd_sel_q][rd_cnt_q[PTR_W-1:0]]  : '0;
    assign left_slice = (rd_state_q == STREAM) ? left_mem[rd_sel_q][rd_cnt_q[PTR_W-1:0]] : '0;

    // First stage of every skew line doubles as the registered bank read,
    // so lane i sits i+1 stages behind the raw bank output.
    for (genvar i = 0; i < N; i++) begin : g_lane
        tpu_operand_sequencer_skew_line #(.DEPTH(i + 1), .DW(DW)) u_top_skew (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .d_i     (top_slice[i*DW +: DW]),
            .q_o     (top_feed[i*DW +: DW])
        );
        tpu_operand_sequencer_skew_line #(.DEPTH(i + 1), .DW(DW)) u_left_skew (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .d_i     (left_slice[i*DW +: DW]),
            .q_o     (left_feed[i*DW +: DW])
        );
    end

    assign bus.load_ready = load_ready;
    assign bus.top_feed   = top_feed;
    assign bus.left_feed  = left_feed;
    assign bus.pe_enable  = pe_enable;
    assign bus.pe_clear   = pe_clear;
    assign bus.tile_done  = tile_done;
    assign bus.overflow   = overflow_q;

endmodule
